// File: rtl/alu_cmd_issue.sv
// Command-issue stage: buffers ALU commands in a small FIFO and evaluates the
// head command into a registered result slot with status flags.
module alu_cmd_issue #(
  parameter int unsigned ARRAY_LENGTH = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [ARRAY_LENGTH-1:0]       cmd_a,
  input  logic [ARRAY_LENGTH-1:0]       cmd_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ARRAY_LENGTH-1:0]       res_data,
  output logic [2:0]                    res_op,
  output logic                          res_ovf,
  output logic                          res_dz,
  output logic                          res_ill,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned W  = ARRAY_LENGTH;
  localparam int unsigned W2 = 2 * W;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 3 + 2 * W;
  localparam int unsigned RW = (W + 1) / 2;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_MUL    = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd3;
  localparam logic [2:0] OP_SQUARE = 3'd4;
  localparam logic [2:0] OP_SQRT   = 3'd5;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          load;

  logic [2:0]    h_op;
  logic [W-1:0]  h_a;
  logic [W-1:0]  h_b;

  logic [W-1:0]  sum;
  logic [W-1:0]  diff;
  logic [W2-1:0] prod;
  logic [W2-1:0] sqr;
  logic [W-1:0]  quot;
  logic [W-1:0]  root;
  logic [W-1:0]  cand;
  logic [W-1:0]  alu_data;
  logic          alu_ovf;
  logic          alu_dz;
  logic          alu_ill;

  assign cmd_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign load      = (fifo_count != '0) && (!res_valid || res_ready);
  assign {h_op, h_a, h_b} = mem[rd_ptr];

  // Operator datapath for the FIFO head; the digit-by-digit root loop is fixed-length.
  always_comb begin
    alu_data = '0;
    alu_ovf  = 1'b0;
    alu_dz   = 1'b0;
    alu_ill  = 1'b0;
    sum      = h_a + h_b;
    diff     = h_a - h_b;
    prod     = W2'(h_a) * W2'(h_b);
    sqr      = W2'(h_a) * W2'(h_a);
    quot     = '0;
    if (h_b != '0) quot = W'($signed(h_a) / $signed(h_b));
    root = '0;
    cand = '0;
    for (int i = int'(RW) - 1; i >= 0; i--) begin
      cand = root | (W'(1) << i);
      if (W2'(cand) * W2'(cand) <= W2'(h_a)) root = cand;
    end

    case (h_op)
      OP_ADD: begin
        alu_data = sum;
        alu_ovf  = (h_a[W-1] == h_b[W-1]) && (sum[W-1] != h_a[W-1]);
      end
      OP_SUB: begin
        alu_data = diff;
        alu_ovf  = (h_a[W-1] != h_b[W-1]) && (diff[W-1] != h_a[W-1]);
      end
      OP_MUL: begin
        alu_data = prod[W-1:0];
        alu_ovf  = (prod[W2-1:W] != '0);
      end
      OP_DIV: begin
        if (h_b == '0) begin
          alu_dz = 1'b1;
        end else if (h_a == {1'b1, {(W-1){1'b0}}} && h_b == '1) begin
          alu_data = h_a;
          alu_ovf  = 1'b1;
        end else begin
          alu_data = quot;
        end
      end
      OP_SQUARE: begin
        alu_data = sqr[W-1:0];
        alu_ovf  = (sqr[W2-1:W] != '0);
      end
      OP_SQRT: alu_data = root;
      default: alu_ill = 1'b1;
    endcase
  end

  // Pointers, occupancy and the result slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_op     <= '0;
      res_ovf    <= 1'b0;
      res_dz     <= 1'b0;
      res_ill    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) begin
        rd_ptr    <= rd_ptr + PW'(1);
        res_valid <= 1'b1;
        res_data  <= alu_data;
        res_op    <= h_op;
        res_ovf   <= alu_ovf;
        res_dz    <= alu_dz;
        res_ill   <= alu_ill;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      fifo_count <= fifo_count + CW'(push) - CW'(load);
    end
  end

  // Command storage needs no reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed self-checking bench for alu_cmd_issue: operator vectors,
// backpressure, streaming and mid-stream reset.
module tb_alu_cmd_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_op;
  logic       res_ovf;
  logic       res_dz;
  logic       res_ill;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  alu_cmd_issue #(.ARRAY_LENGTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .res_ovf(res_ovf), .res_dz(res_dz), .res_ill(res_ill),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command into an idle stage; result expected one edge after acceptance.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_data, input logic [2:0] exp_flags);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    step();
    cmd_valid = 1'b0;
    step();
    check({tag, ".valid"}, 32'(res_valid), 32'd1);
    check({tag, ".data"},  32'(res_data),  32'(exp_data));
    check({tag, ".op"},    32'(res_op),    32'(op));
    check({tag, ".flags"}, 32'({res_ovf, res_dz, res_ill}), 32'(exp_flags));
    check({tag, ".count"}, 32'(fifo_count), 32'd0);
    step();
  endtask

  int  acc;
  logic will;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst.valid", 32'(res_valid), 32'd0);
    check("rst.count", 32'(fifo_count), 32'd0);
    check("rst.ready", 32'(cmd_ready), 32'd1);
    check("rst.data",  32'(res_data), 32'd0);
    check("rst.flags", 32'({res_ovf, res_dz, res_ill, res_op}), 32'd0);

    // flags are {ovf, dz, ill}
    run_op("add_127",  3'd0, 8'd100, 8'd27,  8'd127,  3'b000);
    run_op("add_ovf",  3'd0, 8'd100, 8'd28,  8'h80,   3'b100);
    run_op("sub_ovf",  3'd1, 8'h80,  8'd1,   8'h7F,   3'b100);
    run_op("sub_neg",  3'd1, 8'd5,   8'd9,   8'hFC,   3'b000);
    run_op("div_m7_2", 3'd3, 8'hF9,  8'd2,   8'hFD,   3'b000);
    run_op("div_7_m2", 3'd3, 8'd7,   8'hFE,  8'hFD,   3'b000);
    run_op("div_m8_3", 3'd3, 8'hF8,  8'd3,   8'hFE,   3'b000);
    run_op("div_z",    3'd3, 8'd5,   8'd0,   8'h00,   3'b010);
    run_op("div_ovf",  3'd3, 8'h80,  8'hFF,  8'h80,   3'b100);
    run_op("mul_ff",   3'd2, 8'd15,  8'd17,  8'hFF,   3'b000);
    run_op("mul_ovf",  3'd2, 8'd16,  8'd16,  8'h00,   3'b100);
    run_op("sq_15",    3'd4, 8'd15,  8'h55,  8'd225,  3'b000);
    run_op("sq_16",    3'd4, 8'd16,  8'h00,  8'h00,   3'b100);
    run_op("sqrt_255", 3'd5, 8'd255, 8'h33,  8'd15,   3'b000);
    run_op("sqrt_0",   3'd5, 8'd0,   8'h00,  8'd0,    3'b000);
    run_op("sqrt_16",  3'd5, 8'd16,  8'h00,  8'd4,    3'b000);
    run_op("sqrt_15",  3'd5, 8'd15,  8'h00,  8'd3,    3'b000);
    run_op("ill_6",    3'd6, 8'd9,   8'd9,   8'd0,    3'b001);

    // Backpressure: consumer stalled, producer always offering ADD n+n.
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      cmd_op = 3'd0;
      cmd_a  = 8'(acc + 1);
      cmd_b  = 8'(acc + 1);
      will   = cmd_ready;
      step();
      if (will) acc++;
    end
    cmd_valid = 1'b0;
    check("bp.accepted", 32'(acc), 32'd5);
    check("bp.ready",    32'(cmd_ready), 32'd0);
    check("bp.count",    32'(fifo_count), 32'd4);
    check("bp.valid",    32'(res_valid), 32'd1);
    check("bp.data",     32'(res_data), 32'd2);
    step();
    step();
    check("bp.hold",     32'({res_valid, res_data, res_op, res_ovf, res_dz, res_ill}),
          32'({1'b1, 8'd2, 3'd0, 3'b000}));
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp.drain_valid", 32'(res_valid), 32'd1);
      check("bp.drain_data",  32'(res_data), 32'(2 * (k + 1)));
      step();
      if (k == 0) begin
        check("bp.ready_rise", 32'(cmd_ready), 32'd1);
        check("bp.count3",     32'(fifo_count), 32'd3);
      end
    end
    check("bp.empty", 32'(res_valid), 32'd0);

    // Streaming: one ADD n+0 per cycle, result one edge after acceptance.
    for (int i = 0; i <= 20; i++) begin
      cmd_valid = (i < 20);
      cmd_op    = 3'd0;
      cmd_a     = 8'(i + 1);
      cmd_b     = 8'd0;
      step();
      if (i >= 1) begin
        check("st.valid", 32'(res_valid), 32'd1);
        check("st.data",  32'(res_data), 32'(i));
      end
      check("st.count_le1", 32'(fifo_count <= 3'd1), 32'd1);
    end
    cmd_valid = 1'b0;
    step();
    check("st.done", 32'(res_valid), 32'd0);

    // Mid-stream reset with three queued and the slot full.
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_op = 3'd2;
      cmd_a  = 8'(i + 3);
      cmd_b  = 8'd7;
      step();
    end
    cmd_valid = 1'b0;
    check("mr.pre_count", 32'(fifo_count), 32'd3);
    check("mr.pre_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr.valid", 32'(res_valid), 32'd0);
    check("mr.count", 32'(fifo_count), 32'd0);
    check("mr.ready", 32'(cmd_ready), 32'd1);
    step();
    check("mr.no_stale", 32'(res_valid), 32'd0);
    res_ready = 1'b1;
    run_op("mr.add_1_1", 3'd0, 8'd1, 8'd1, 8'd2, 3'b000);
    run_op("ill_7",      3'd7, 8'd4, 8'd4, 8'd0, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
